// File: rtl/sobel_frame_ctrl_pkg.sv
// Shared types and defaults for the Sobel frame sequencer (package sobel_ctrl_pkg).
// Mode encoding matches the host register field; code 11 folds to BYPASS.
package sobel_ctrl_pkg;

    localparam int H_ACTIVE_DEF  = 640;
    localparam int V_ACTIVE_DEF  = 480;
    localparam int DEF_SHIFT_DEF = 4;

    typedef enum logic [1:0] {
        BYPASS    = 2'b00,
        SOBEL     = 2'b01,
        SOBEL_INV = 2'b10
    } mode_e;

    typedef enum logic [1:0] {
        SYNC   = 2'b00,
        ARMED  = 2'b01,
        ACTIVE = 2'b10,
        DONE   = 2'b11
    } state_e;

    function automatic mode_e decode_mode(input logic [1:0] raw);
        case (raw)
            2'b01:   return SOBEL;
            2'b10:   return SOBEL_INV;
            default: return BYPASS;
        endcase
    endfunction

endpackage

// File: rtl/sobel_frame_ctrl_xy_counter.sv
// Pixel column/row counters (module sobel_xy_counter). Column wraps at the line end,
// row saturates at V_ACTIVE; any pixel beyond that raises a sticky overflow until clr.
module sobel_xy_counter #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        en,
    output logic [$clog2(H_ACTIVE)-1:0] x,
    output logic [$clog2(V_ACTIVE)-1:0] y,
    output logic                        ovf
);

    localparam int XW = $clog2(H_ACTIVE);
    localparam int YW = $clog2(V_ACTIVE);
    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_END  = YW'(V_ACTIVE);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            x   <= '0;
            y   <= '0;
            ovf <= 1'b0;
        end else if (en) begin
            if (y == Y_END) begin
                ovf <= 1'b1;
            end else if (x == X_LAST) begin
                x <= '0;
                y <= y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for the Sobel pipeline: position tracking, window clear, and
// frame-boundary config apply. Optional statistics counters under SOBEL_CTRL_STATS_EN.
module sobel_frame_ctrl
    import sobel_ctrl_pkg::*;
#(
    parameter int H_ACTIVE  = H_ACTIVE_DEF,
    parameter int V_ACTIVE  = V_ACTIVE_DEF,
    parameter int DEF_SHIFT = DEF_SHIFT_DEF
) (
    input  logic                        iCLK,
    input  logic                        iRST,
    input  logic                        iFVAL,
    input  logic                        iDVAL,
    input  logic                        iCFG_REQ,
    input  logic [1:0]                  iCFG_MODE,
    input  logic [2:0]                  iCFG_SHIFT,
    output logic                        oCFG_ACK,
    output logic [1:0]                  oMODE,
    output logic [2:0]                  oMAG_SHIFT,
    output logic [$clog2(H_ACTIVE)-1:0] oX,
    output logic [$clog2(V_ACTIVE)-1:0] oY,
    output logic                        oBORDER,
    output logic                        oSOF,
    output logic                        oEOF,
    output logic                        oWIN_CLR,
    output logic                        oFRAME_ERR,
    output logic [15:0]                 oFRAME_CNT,
    output logic [7:0]                  oERR_CNT
);

    localparam int XW = $clog2(H_ACTIVE);
    localparam int YW = $clog2(V_ACTIVE);
    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);
    localparam logic [YW-1:0] Y_END  = YW'(V_ACTIVE);

    state_e     state;
    mode_e      mode_q;
    mode_e      pend_mode;
    logic [2:0] pend_shift;
    logic       pend_valid;
    logic       ovf;
    logic       start;
    logic       active;
    logic       count_en;
    logic       bad_frame;

    assign start    = (state == ARMED) && iFVAL;
    assign active   = (state == ACTIVE);
    assign count_en = active && iDVAL;

    sobel_xy_counter #(
        .H_ACTIVE(H_ACTIVE),
        .V_ACTIVE(V_ACTIVE)
    ) u_xy (
        .clk(iCLK),
        .rst(iRST),
        .clr(start),
        .en (count_en),
        .x  (oX),
        .y  (oY),
        .ovf(ovf)
    );

    assign bad_frame = ovf || (oX != '0) || (oY != Y_END);
    assign oBORDER   = active && ((oX == '0) || (oX == X_LAST) || (oY == '0) || (oY == Y_LAST));
    assign oSOF      = count_en && (oX == '0) && (oY == '0);
    assign oEOF      = count_en && (oX == X_LAST) && (oY == Y_LAST);
    assign oMODE     = mode_q;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state      <= SYNC;
            mode_q     <= BYPASS;
            oMAG_SHIFT <= 3'(DEF_SHIFT);
            pend_valid <= 1'b0;
            pend_mode  <= BYPASS;
            pend_shift <= '0;
            oCFG_ACK   <= 1'b0;
            oWIN_CLR   <= 1'b0;
            oFRAME_ERR <= 1'b0;
        end else begin
            oCFG_ACK <= 1'b0;
            oWIN_CLR <= 1'b0;
            case (state)
                SYNC:   if (!iFVAL) state <= ARMED;
                ARMED:  if (iFVAL) begin
                            state    <= ACTIVE;
                            oWIN_CLR <= 1'b1;
                        end
                ACTIVE: if (!iFVAL) state <= DONE;
                DONE:   begin
                            state <= ARMED;
                            if (bad_frame) oFRAME_ERR <= 1'b1;
                        end
                default: state <= SYNC;
            endcase
            // The host still holds REQ during the ack cycle, so capture is blocked then.
            if (start && pend_valid) begin
                mode_q     <= pend_mode;
                oMAG_SHIFT <= pend_shift;
                oCFG_ACK   <= 1'b1;
                pend_valid <= 1'b0;
            end else if (iCFG_REQ && !pend_valid && !oCFG_ACK) begin
                pend_mode  <= decode_mode(iCFG_MODE);
                pend_shift <= iCFG_SHIFT;
                pend_valid <= 1'b1;
            end
        end
    end

`ifdef SOBEL_CTRL_STATS_EN
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else if (state == DONE) begin
            frame_cnt <= frame_cnt + 1'b1;
            if (bad_frame && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 1'b1;
        end
    end

    assign oFRAME_CNT = frame_cnt;
    assign oERR_CNT   = err_cnt;
`else
    assign oFRAME_CNT = '0;
    assign oERR_CNT   = '0;
`endif

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Directed bench for sobel_frame_ctrl on a reduced 8x6 frame; stats expectations
// follow SOBEL_CTRL_STATS_EN when it is defined for the build.
module tb_sobel_frame_ctrl;
    import sobel_ctrl_pkg::*;

    localparam int H  = 8;
    localparam int V  = 6;
    localparam int XW = $clog2(H);
    localparam int YW = $clog2(V);
    localparam int BORDER_PIX = 2 * H + 2 * (V - 2);
`ifdef SOBEL_CTRL_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic          iCLK = 1'b0;
    logic          iRST = 1'b1;
    logic          iFVAL = 1'b1;
    logic          iDVAL = 1'b0;
    logic          iCFG_REQ = 1'b0;
    logic [1:0]    iCFG_MODE = 2'b00;
    logic [2:0]    iCFG_SHIFT = 3'd0;
    logic          oCFG_ACK;
    logic [1:0]    oMODE;
    logic [2:0]    oMAG_SHIFT;
    logic [XW-1:0] oX;
    logic [YW-1:0] oY;
    logic          oBORDER, oSOF, oEOF, oWIN_CLR, oFRAME_ERR;
    logic [15:0]   oFRAME_CNT;
    logic [7:0]    oERR_CNT;

    int checks = 0;
    int errors = 0;
    int n_clr = 0, n_ack = 0, n_ack_solo = 0, n_sof = 0, n_eof = 0, n_border = 0;
    int s_clr, s_ack, s_ack_solo, s_sof, s_eof, s_border;

    int         ev_pix[4];
    logic       ev_req[4];
    logic [1:0] ev_mode[4];
    logic [2:0] ev_shift[4];

    always #5 iCLK = ~iCLK;

    sobel_frame_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .DEF_SHIFT(4)) dut (
        .iCLK(iCLK), .iRST(iRST), .iFVAL(iFVAL), .iDVAL(iDVAL),
        .iCFG_REQ(iCFG_REQ), .iCFG_MODE(iCFG_MODE), .iCFG_SHIFT(iCFG_SHIFT),
        .oCFG_ACK(oCFG_ACK), .oMODE(oMODE), .oMAG_SHIFT(oMAG_SHIFT),
        .oX(oX), .oY(oY), .oBORDER(oBORDER), .oSOF(oSOF), .oEOF(oEOF),
        .oWIN_CLR(oWIN_CLR), .oFRAME_ERR(oFRAME_ERR),
        .oFRAME_CNT(oFRAME_CNT), .oERR_CNT(oERR_CNT)
    );

    always @(negedge iCLK) begin
        if (!iRST) begin
            if (oWIN_CLR) n_clr++;
            if (oCFG_ACK) n_ack++;
            if (oCFG_ACK && !oWIN_CLR) n_ack_solo++;
            if (iDVAL && oSOF) n_sof++;
            if (iDVAL && oEOF) n_eof++;
            if (iDVAL && oBORDER) n_border++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic snap();
        s_clr = n_clr; s_ack = n_ack; s_ack_solo = n_ack_solo;
        s_sof = n_sof; s_eof = n_eof; s_border = n_border;
    endtask

    task automatic clear_ev();
        for (int i = 0; i < 4; i++) ev_pix[i] = -99;
    endtask

    task automatic set_ev(input int i, input int p, input logic r, input logic [1:0] m, input logic [2:0] s);
        ev_pix[i] = p; ev_req[i] = r; ev_mode[i] = m; ev_shift[i] = s;
    endtask

    task automatic apply_ev(input int p);
        for (int i = 0; i < 4; i++)
            if (ev_pix[i] == p) begin
                iCFG_REQ = ev_req[i]; iCFG_MODE = ev_mode[i]; iCFG_SHIFT = ev_shift[i];
            end
    endtask

    // Host side: REQ is released as soon as the ack pulse is seen.
    task automatic cyc(input logic fv, input logic dv);
        @(posedge iCLK);
        #1;
        if (oCFG_ACK) iCFG_REQ = 1'b0;
        iFVAL = fv;
        iDVAL = dv;
    endtask

    task automatic frame(input int lines, input int extra, input bit chk_xy, input int rst_pix);
        int p = 0;
        cyc(1'b1, 1'b0);
        apply_ev(-1);
        for (int ly = 0; ly < lines; ly++) begin
            for (int lx = 0; lx < H; lx++) begin
                cyc(1'b1, 1'b1);
                iRST = (p == rst_pix);
                apply_ev(p);
                #2;
                if (chk_xy) begin
                    chk("x", 32'(oX), 32'(lx));
                    chk("y", 32'(oY), 32'(ly));
                end
                p++;
                if (lx == 3) cyc(1'b1, 1'b0);
            end
        end
        for (int e = 0; e < extra; e++) begin
            cyc(1'b1, 1'b1);
            #2;
            if (chk_xy) begin
                chk("x_extra", 32'(oX), 32'd0);
                chk("y_extra", 32'(oY), 32'(V));
            end
        end
        cyc(1'b0, 1'b0);
        iRST = 1'b0;
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        clear_ev();
    endtask

    initial begin
        clear_ev();
        repeat (3) @(posedge iCLK);
        #2;
        chk("rst_mode", 32'(oMODE), 32'd0);
        chk("rst_shift", 32'(oMAG_SHIFT), 32'd4);
        chk("rst_x", 32'(oX), 32'd0);
        chk("rst_y", 32'(oY), 32'd0);
        chk("rst_ack", 32'(oCFG_ACK), 32'd0);
        chk("rst_clr", 32'(oWIN_CLR), 32'd0);
        chk("rst_ferr", 32'(oFRAME_ERR), 32'd0);
        chk("rst_border", 32'(oBORDER), 32'd0);
        chk("rst_fcnt", 32'(oFRAME_CNT), 32'd0);
        chk("rst_ecnt", 32'(oERR_CNT), 32'd0);
        @(posedge iCLK);
        #1;
        iRST = 1'b0;

        // iFVAL high out of reset: this frame must be ignored entirely.
        snap();
        frame(V, 0, 1'b0, -1);
        chk("sync_clr", 32'(n_clr - s_clr), 32'd0);
        chk("sync_sof", 32'(n_sof - s_sof), 32'd0);
        chk("sync_eof", 32'(n_eof - s_eof), 32'd0);

        snap();
        frame(V, 0, 1'b1, -1);
        chk("good_clr", 32'(n_clr - s_clr), 32'd1);
        chk("good_sof", 32'(n_sof - s_sof), 32'd1);
        chk("good_eof", 32'(n_eof - s_eof), 32'd1);
        chk("good_border", 32'(n_border - s_border), 32'(BORDER_PIX));
        chk("good_ferr", 32'(oFRAME_ERR), 32'd0);
        chk("good_ack", 32'(n_ack - s_ack), 32'd0);
        chk("good_fcnt", 32'(oFRAME_CNT), 32'(STATS * 1));

        snap();
        frame(V - 1, 0, 1'b1, -1);
        chk("short_ferr", 32'(oFRAME_ERR), 32'd1);
        chk("short_ecnt", 32'(oERR_CNT), 32'(STATS * 1));
        chk("short_eof", 32'(n_eof - s_eof), 32'd0);
        chk("short_sof", 32'(n_sof - s_sof), 32'd1);

        frame(V, 0, 1'b1, -1);
        chk("sticky_ferr", 32'(oFRAME_ERR), 32'd1);
        chk("sticky_ecnt", 32'(oERR_CNT), 32'(STATS * 1));
        chk("sticky_fcnt", 32'(oFRAME_CNT), 32'(STATS * 3));

        // Mid-frame request: held until the next frame start.
        set_ev(0, 10, 1'b1, 2'b01, 3'd3);
        snap();
        frame(V, 0, 1'b1, -1);
        chk("mid_mode_hold", 32'(oMODE), 32'd0);
        chk("mid_shift_hold", 32'(oMAG_SHIFT), 32'd4);
        chk("mid_ack_none", 32'(n_ack - s_ack), 32'd0);
        snap();
        frame(V, 0, 1'b1, -1);
        chk("mid_ack", 32'(n_ack - s_ack), 32'd1);
        chk("mid_ack_align", 32'(n_ack_solo - s_ack_solo), 32'd0);
        chk("mid_clr", 32'(n_clr - s_clr), 32'd1);
        chk("mid_mode", 32'(oMODE), 32'd1);
        chk("mid_shift", 32'(oMAG_SHIFT), 32'd3);

        // Reserved mode code folds to bypass.
        set_ev(0, 0, 1'b1, 2'b11, 3'd6);
        frame(V, 0, 1'b1, -1);
        chk("rsv_mode_hold", 32'(oMODE), 32'd1);
        snap();
        frame(V, 0, 1'b1, -1);
        chk("rsv_ack", 32'(n_ack - s_ack), 32'd1);
        chk("rsv_mode", 32'(oMODE), 32'd0);
        chk("rsv_shift", 32'(oMAG_SHIFT), 32'd6);

        // Request coincident with frame start, then a second request while pending.
        set_ev(0, -1, 1'b1, 2'b10, 3'd2);
        set_ev(1, 2, 1'b0, 2'b10, 3'd2);
        set_ev(2, 5, 1'b1, 2'b01, 3'd7);
        set_ev(3, 8, 1'b0, 2'b01, 3'd7);
        snap();
        frame(V, 0, 1'b1, -1);
        chk("col_ack_none", 32'(n_ack - s_ack), 32'd0);
        chk("col_mode_hold", 32'(oMODE), 32'd0);
        chk("col_shift_hold", 32'(oMAG_SHIFT), 32'd6);
        snap();
        frame(V, 0, 1'b1, -1);
        chk("col_ack", 32'(n_ack - s_ack), 32'd1);
        chk("col_mode", 32'(oMODE), 32'd2);
        chk("col_shift", 32'(oMAG_SHIFT), 32'd2);
        snap();
        frame(V, 0, 1'b1, -1);
        chk("second_ignored_ack", 32'(n_ack - s_ack), 32'd0);
        chk("second_ignored_mode", 32'(oMODE), 32'd2);
        chk("second_ignored_shift", 32'(oMAG_SHIFT), 32'd2);
        chk("pre_rst_fcnt", 32'(oFRAME_CNT), 32'(STATS * 10));

        // Reset pulsed at pixel (3,2) of a frame.
        frame(V, 0, 1'b0, 2 * H + 3);
        chk("mrst_mode", 32'(oMODE), 32'd0);
        chk("mrst_shift", 32'(oMAG_SHIFT), 32'd4);
        chk("mrst_ferr", 32'(oFRAME_ERR), 32'd0);
        chk("mrst_x", 32'(oX), 32'd0);
        chk("mrst_y", 32'(oY), 32'd0);
        chk("mrst_fcnt", 32'(oFRAME_CNT), 32'd0);
        chk("mrst_ecnt", 32'(oERR_CNT), 32'd0);
        snap();
        frame(V, 0, 1'b1, -1);
        chk("post_rst_clr", 32'(n_clr - s_clr), 32'd1);
        chk("post_rst_sof", 32'(n_sof - s_sof), 32'd1);
        chk("post_rst_eof", 32'(n_eof - s_eof), 32'd1);
        chk("post_rst_ferr", 32'(oFRAME_ERR), 32'd0);
        chk("post_rst_fcnt", 32'(oFRAME_CNT), 32'(STATS * 1));

        // Excess pixels: final position looks correct, overflow alone flags the frame.
        frame(V, 2, 1'b1, -1);
        chk("excess_ferr", 32'(oFRAME_ERR), 32'd1);
        chk("excess_ecnt", 32'(oERR_CNT), 32'(STATS * 1));
        chk("excess_fcnt", 32'(oFRAME_CNT), 32'(STATS * 2));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sobel_frame_ctrl.md
# sobel_frame_ctrl

Frame-level sequencer for the Sobel edge pipeline. It sits beside the Sobel processing block on the 12-bit grayscale stream. It tracks frame and line position from the sensor's frame and data valids, and clears the 3x3 window line buffers at each frame start. It also latches host configuration (mode and magnitude shift) through a request/acknowledge handshake, applying it only on frame boundaries so a frame is never processed with mixed settings.

## Interface
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- DEF_SHIFT, 4, magnitude shift applied after reset
- iCLK  in  1  single clock; all logic on rising edge
- iRST  in  1  synchronous, active-high reset
- iFVAL  in  1  frame valid from sensor path
- iDVAL  in  1  pixel valid; one pixel per asserted cycle
- iCFG_REQ  in  1  host config request (level, held until ack)
- iCFG_MODE  in  2  00 bypass, 01 sobel, 10 sobel inverted, 11 reserved (treated as bypass)
- iCFG_SHIFT  in  3  requested magnitude shift
- oCFG_ACK  out  1  one-cycle pulse: pending config applied
- oMODE  out  2  active mode for current frame
- oMAG_SHIFT  out  3  active shift for current frame
- oX  out  $clog2(H_ACTIVE)  column of pixel on iDVAL this cycle
- oY  out  $clog2(V_ACTIVE)  row of pixel on iDVAL this cycle
- oBORDER  out  1  current pixel is on the frame border
- oSOF / oEOF  out  1 each  first / last pixel of frame (qualified by iDVAL)
- oWIN_CLR  out  1  one-cycle pulse clearing window line buffers
- oFRAME_ERR  out  1  sticky: frame ended with wrong pixel count
- oFRAME_CNT  out  16  completed frames (stats build only)
- oERR_CNT  out  8  bad frames, saturating (stats build only)

## Operation
- FSM states: SYNC (wait iFVAL=0), ARMED (wait iFVAL rising), ACTIVE (counting), DONE (one cycle).
- SYNC→ARMED when iFVAL=0. ARMED→ACTIVE on iFVAL=1.
- On ARMED→ACTIVE: pulse oWIN_CLR, zero X/Y, apply pending config.
- ACTIVE→DONE on iFVAL=0. DONE→ARMED unconditionally.
- Counting: in ACTIVE, iDVAL increments X. At X=H_ACTIVE-1, X wraps to 0 and Y increments. Gaps in iDVAL are allowed mid-line.
- Excess pixels:
  - iDVAL after Y reaches V_ACTIVE is ignored for counting.
  - Y holds at V_ACTIVE.
  - Sets the error condition for the frame.
- Frame check in DONE: the frame is bad unless X=0 and Y=V_ACTIVE. A bad frame sets oFRAME_ERR, cleared only by reset.
- oBORDER = ACTIVE & (X=0 | X=H_ACTIVE-1 | Y=0 | Y=V_ACTIVE-1).
- oSOF = ACTIVE & iDVAL & X=0 & Y=0.
- oEOF = ACTIVE & iDVAL & X=H_ACTIVE-1 & Y=V_ACTIVE-1.
- Config capture: iCFG_REQ=1 with no pending entry captures MODE/SHIFT into the pending register. Mode 11 is stored as 00.
- While an entry is pending, further requests are ignored.
- Config apply: pending is copied to oMODE/oMAG_SHIFT at the ARMED→ACTIVE transition, with a oCFG_ACK pulse that same cycle.
- Host rules: the host must deassert iCFG_REQ for at least one cycle after ack. Dropping iCFG_REQ before ack does not cancel an already captured entry.

## Timing
- oBORDER, oSOF, oEOF, oX, oY: zero latency, aligned with the iDVAL cycle of the pixel they describe.
- oWIN_CLR and oCFG_ACK: asserted in the cycle after iFVAL is first sampled high in ARMED.
- Capture/apply collision: a request captured in the same cycle as an apply is not applied. It waits for the next frame start.
- Reset values:
  - state SYNC
  - X=Y=0
  - oMODE=00, oMAG_SHIFT=DEF_SHIFT
  - pending empty
  - all pulses 0, oFRAME_ERR=0, counters 0
- Reset mid-frame: the partial frame is discarded. The FSM resynchronises via SYNC, so the first frame seen starts cleanly.
- Startup: iFVAL high at reset release keeps the FSM in SYNC until iFVAL falls.

## Configuration
- SOBEL_CTRL_STATS_EN defined:
  - oFRAME_CNT increments in DONE (wraps at 2^16).
  - oERR_CNT increments on bad frames (saturates at 255).
- SOBEL_CTRL_STATS_EN undefined: both ports remain present and are tied to 0, so the interface is identical in both builds.

## Structure
- Package sobel_ctrl_pkg holds:
  - mode enum (BYPASS, SOBEL, SOBEL_INV)
  - FSM state enum
  - H_ACTIVE/V_ACTIVE defaults
- Sub-module sobel_xy_counter holds the X/Y counters: wrap, saturation, clear input and overflow flag.
- The FSM, config handshake and stats stay in the top module.

## Test plan
- Reset release with iFVAL=1, then one full 640x480 frame → no oWIN_CLR until iFVAL falls and rises; the following frame gives one oSOF, one oEOF, and oFRAME_ERR=0.
- Frame of 640x479 pixels → oFRAME_ERR=1 at frame end; oERR_CNT=1 with the stats macro; the next good frame leaves oFRAME_ERR set.
- Mid-frame request with mode 01, shift 3 → oMODE/oMAG_SHIFT unchanged until the next frame start; oCFG_ACK pulses exactly once, coincident with oWIN_CLR.
- Request asserted in the same cycle as frame start → applied one frame later; a second request while pending is ignored.
- Border check on a 640x480 frame → oBORDER high for exactly 2236 pixels (2·640 + 2·478).
- iRST pulsed at pixel (100,200) → outputs return to reset values; the next complete frame counts correctly, giving oFRAME_CNT=1.
